// File: rtl/level_timer_ctrl.sv
// Level sequencer and 3-digit BCD countdown for a timed defuse game.
// Walks WAIT/LOAD/RUN/PASS per level and ends in BOOM (timeout) or WIN (final level cleared).
module level_timer_ctrl #(
  parameter logic [7:0] LAST_LEVEL = 8'd10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       sec_tick,
  input  logic       level_done,
  input  logic [3:0] load_three,
  input  logic [3:0] load_two,
  input  logic [3:0] load_one,
  output logic [7:0] game_level,
  output logic [3:0] digit_three,
  output logic [3:0] digit_two,
  output logic [3:0] digit_one,
  output logic       running,
  output logic       level_up,
  output logic       exploded,
  output logic       won
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WAIT = 3'd1,
    LOAD = 3'd2,
    RUN  = 3'd3,
    PASS = 3'd4,
    BOOM = 3'd5,
    WIN  = 3'd6
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [7:0]  level_s;
  logic [11:0] count_s;
  logic [11:0] count_now_s;
  logic [11:0] count_dec_s;

  // Borrow ripples from units to hundreds; every digit stays within 0..9.
  function automatic logic [11:0] bcd_dec(input logic [11:0] v);
    logic [3:0] d3;
    logic [3:0] d2;
    logic [3:0] d1;
    d3 = v[11:8];
    d2 = v[7:4];
    d1 = v[3:0];
    if (d1 != 4'd0) begin
      d1 = d1 - 4'd1;
    end else begin
      d1 = 4'd9;
      if (d2 != 4'd0) begin
        d2 = d2 - 4'd1;
      end else begin
        d2 = 4'd9;
        if (d3 != 4'd0) begin
          d3 = d3 - 4'd1;
        end else begin
          d3 = 4'd9;
        end
      end
    end
    return {d3, d2, d1};
  endfunction

  assign count_now_s = {digit_three, digit_two, digit_one};
  assign count_dec_s = bcd_dec(count_now_s);

  // Next-state, next-level and next-count decode.
  always_comb begin
    state_s = state_r;
    level_s = game_level;
    count_s = count_now_s;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = WAIT;
          level_s = 8'd0;
        end else begin
          state_s = IDLE;
        end
      end
      WAIT: state_s = LOAD;
      LOAD: begin
        count_s = {load_three, load_two, load_one};
        state_s = RUN;
      end
      RUN: begin
        // An empty count explodes even if the level was defused this cycle.
        if (count_now_s == 12'h000) begin
          state_s = BOOM;
        end else if (level_done) begin
          state_s = PASS;
        end else if (sec_tick) begin
          count_s = count_dec_s;
          if (count_dec_s == 12'h000) begin
            state_s = BOOM;
          end else begin
            state_s = RUN;
          end
        end else begin
          state_s = RUN;
        end
      end
      PASS: begin
        if (game_level == LAST_LEVEL) begin
          state_s = WIN;
        end else begin
          level_s = game_level + 8'd1;
          state_s = WAIT;
        end
      end
      BOOM: begin
        count_s = 12'h000;
        if (start) begin
          state_s = WAIT;
          level_s = 8'd0;
        end else begin
          state_s = BOOM;
        end
      end
      WIN: begin
        if (start) begin
          state_s = WAIT;
          level_s = 8'd0;
        end else begin
          state_s = WIN;
        end
      end
      default: begin
        state_s = IDLE;
        level_s = 8'd0;
        count_s = 12'h000;
      end
    endcase
  end

  // State, level, digits and status flags all update together so flags track the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      game_level  <= 8'd0;
      digit_three <= 4'd0;
      digit_two   <= 4'd0;
      digit_one   <= 4'd0;
      running     <= 1'b0;
      level_up    <= 1'b0;
      exploded    <= 1'b0;
      won         <= 1'b0;
    end else begin
      state_r     <= state_s;
      game_level  <= level_s;
      digit_three <= count_s[11:8];
      digit_two   <= count_s[7:4];
      digit_one   <= count_s[3:0];
      running     <= (state_s == RUN);
      level_up    <= (state_s == PASS);
      exploded    <= (state_s == BOOM);
      won         <= (state_s == WIN);
    end
  end

endmodule

// File: tb/tb_level_timer_ctrl.sv
// Bench for level_timer_ctrl: directed vector table, corner sequences, then random play
// checked against an integer-seconds model of the game.
module tb_level_timer_ctrl;

  localparam int LAST = 10;
  localparam int P_IDLE = 0, P_WAIT = 1, P_LOAD = 2, P_RUN = 3, P_PASS = 4, P_BOOM = 5, P_WIN = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       sec_tick = 1'b0;
  logic       level_done = 1'b0;
  logic [3:0] load_three = 4'd0;
  logic [3:0] load_two = 4'd0;
  logic [3:0] load_one = 4'd0;
  logic [7:0] game_level;
  logic [3:0] digit_three, digit_two, digit_one;
  logic       running, level_up, exploded, won;

  int vectors = 0;
  int miscompares = 0;

  int m_ph = P_IDLE;
  int m_lvl = 0;
  int m_cnt = 0;

  typedef struct {
    logic        st;
    logic        tk;
    logic        ld;
    logic [11:0] ldv;
    logic [7:0]  lvl;
    logic [11:0] dig;
    logic [3:0]  flg;
  } vec_t;

  vec_t tbl[12];

  level_timer_ctrl #(.LAST_LEVEL(8'd10)) dut (
    .clk(clk), .reset(reset), .start(start), .sec_tick(sec_tick), .level_done(level_done),
    .load_three(load_three), .load_two(load_two), .load_one(load_one),
    .game_level(game_level), .digit_three(digit_three), .digit_two(digit_two),
    .digit_one(digit_one), .running(running), .level_up(level_up),
    .exploded(exploded), .won(won)
  );

  always #5 clk = ~clk;

  task automatic compare(input string name, input logic [7:0] lvl, input logic [11:0] dig,
                         input logic [3:0] flg);
    logic [11:0] got_dig;
    logic [3:0]  got_flg;
    got_dig = {digit_three, digit_two, digit_one};
    got_flg = {running, level_up, exploded, won};
    vectors++;
    if (game_level !== lvl || got_dig !== dig || got_flg !== flg) begin
      miscompares++;
      $display("FAIL %s @%0t: got lvl=%0d dig=%h flags=%b, expected lvl=%0d dig=%h flags=%b",
               name, $time, game_level, got_dig, got_flg, lvl, dig, flg);
    end
  endtask

  task automatic model_reset();
    m_ph = P_IDLE;
    m_lvl = 0;
    m_cnt = 0;
  endtask

  // Game rules on whole seconds; the digits are just the decimal view of m_cnt.
  task automatic model_step();
    case (m_ph)
      P_IDLE, P_BOOM, P_WIN: if (start) begin m_ph = P_WAIT; m_lvl = 0; end
      P_WAIT: m_ph = P_LOAD;
      P_LOAD: begin
        m_cnt = 100 * int'(load_three) + 10 * int'(load_two) + int'(load_one);
        m_ph = P_RUN;
      end
      P_RUN: begin
        if (m_cnt == 0) m_ph = P_BOOM;
        else if (level_done) m_ph = P_PASS;
        else if (sec_tick) begin
          m_cnt = m_cnt - 1;
          if (m_cnt == 0) m_ph = P_BOOM;
        end
      end
      P_PASS: if (m_lvl == LAST) m_ph = P_WIN; else begin m_lvl = m_lvl + 1; m_ph = P_WAIT; end
      default: m_ph = P_IDLE;
    endcase
  endtask

  task automatic check_model(input string name);
    logic [11:0] d;
    d = {4'(m_cnt / 100), 4'((m_cnt / 10) % 10), 4'(m_cnt % 10)};
    compare(name, 8'(m_lvl), d,
            {m_ph == P_RUN, m_ph == P_PASS, m_ph == P_BOOM, m_ph == P_WIN});
  endtask

  task automatic step(input logic st, input logic tk, input logic ld, input logic [11:0] ldv);
    start = st;
    sec_tick = tk;
    level_done = ld;
    {load_three, load_two, load_one} = ldv;
    @(posedge clk);
    model_step();
    #1;
    check_model("model");
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    sec_tick = 1'b0;
    level_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    compare("reset", 8'd0, 12'h000, 4'b0000);
    reset = 1'b0;
  endtask

  // From IDLE: start, then clear n levels; ends in WAIT at level n.
  task automatic advance_levels(input int n);
    step(1'b1, 1'b0, 1'b0, 12'h005);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b0, 1'b0, 12'h005);
      step(1'b0, 1'b0, 1'b0, 12'h005);
      step(1'b0, 1'b1, 1'b1, 12'h005);
      step(1'b0, 1'b0, 1'b0, 12'h005);
    end
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 12'h200, 8'd0, 12'h000, 4'b0000};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 12'h200, 8'd0, 12'h000, 4'b0000};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 12'h200, 8'd0, 12'h200, 4'b1000};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 12'h200, 8'd0, 12'h199, 4'b1000};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 12'h200, 8'd0, 12'h199, 4'b0100};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 12'h002, 8'd1, 12'h199, 4'b0000};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 12'h002, 8'd1, 12'h199, 4'b0000};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 12'h002, 8'd1, 12'h002, 4'b1000};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 12'h002, 8'd1, 12'h001, 4'b1000};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 12'h002, 8'd1, 12'h000, 4'b0010};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 12'h002, 8'd1, 12'h000, 4'b0010};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 12'h002, 8'd0, 12'h000, 4'b0000};

    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].st, tbl[i].tk, tbl[i].ld, tbl[i].ldv);
      compare($sformatf("table[%0d]", i), tbl[i].lvl, tbl[i].dig, tbl[i].flg);
    end

    // Long countdown across both borrows: 200 -> 199 -> 099.
    do_reset();
    step(1'b1, 1'b0, 1'b0, 12'h200);
    step(1'b0, 1'b0, 1'b0, 12'h200);
    step(1'b0, 1'b0, 1'b0, 12'h200);
    for (int i = 0; i < 101; i++) step(1'b0, 1'b1, 1'b0, 12'h200);
    compare("count_099", 8'd0, 12'h099, 4'b1000);

    // Simultaneous level_done and tick at 001: pass wins, count frozen.
    do_reset();
    step(1'b1, 1'b0, 1'b0, 12'h001);
    step(1'b0, 1'b0, 1'b0, 12'h001);
    step(1'b0, 1'b0, 1'b0, 12'h001);
    step(1'b0, 1'b1, 1'b1, 12'h001);
    compare("pass_at_001", 8'd0, 12'h001, 4'b0100);
    step(1'b0, 1'b0, 1'b0, 12'h001);
    compare("pass_to_wait", 8'd1, 12'h001, 4'b0000);

    // Zero load explodes on the next edge even with level_done.
    do_reset();
    step(1'b1, 1'b0, 1'b0, 12'h000);
    step(1'b0, 1'b0, 1'b0, 12'h000);
    step(1'b0, 1'b0, 1'b0, 12'h000);
    compare("run_at_000", 8'd0, 12'h000, 4'b1000);
    step(1'b0, 1'b0, 1'b1, 12'h000);
    compare("zero_boom", 8'd0, 12'h000, 4'b0010);

    // Clear the final level: WIN keeps level 10 and digits; restart goes to level 0.
    do_reset();
    advance_levels(10);
    step(1'b0, 1'b0, 1'b0, 12'h037);
    step(1'b0, 1'b0, 1'b0, 12'h037);
    step(1'b0, 1'b1, 1'b0, 12'h037);
    step(1'b0, 1'b0, 1'b1, 12'h037);
    compare("last_pass", 8'd10, 12'h036, 4'b0100);
    step(1'b0, 1'b0, 1'b0, 12'h037);
    compare("win", 8'd10, 12'h036, 4'b0001);
    step(1'b0, 1'b1, 1'b1, 12'h037);
    compare("win_hold", 8'd10, 12'h036, 4'b0001);
    step(1'b1, 1'b0, 1'b0, 12'h037);
    compare("win_restart", 8'd0, 12'h036, 4'b0000);

    // Asynchronous reset mid-RUN at level 5, then idle until start.
    do_reset();
    advance_levels(5);
    step(1'b0, 1'b0, 1'b0, 12'h050);
    step(1'b0, 1'b0, 1'b0, 12'h050);
    step(1'b0, 1'b1, 1'b0, 12'h050);
    compare("run_lvl5", 8'd5, 12'h049, 4'b1000);
    #2 reset = 1'b1;
    #1;
    model_reset();
    compare("async_reset", 8'd0, 12'h000, 4'b0000);
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    compare("start_in_reset", 8'd0, 12'h000, 4'b0000);
    #2 reset = 1'b0;
    step(1'b0, 1'b1, 1'b1, 12'h050);
    compare("idle_ignores", 8'd0, 12'h000, 4'b0000);
    step(1'b1, 1'b0, 1'b0, 12'h050);
    compare("first_start", 8'd0, 12'h000, 4'b0000);
    step(1'b0, 1'b0, 1'b1, 12'h050);
    compare("wait_ignores_ld", 8'd0, 12'h000, 4'b0000);

    // Random play against the model, with occasional resets.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      step($urandom_range(0, 19) == 0, 1'($urandom_range(0, 1)), $urandom_range(0, 11) == 0,
           {4'($urandom_range(0, 1)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/level_timer_ctrl.md
LEVEL_TIMER_CTRL -- requirements
Module: level_timer_ctrl

Interface
REQ-001 SHALL have parameter LAST_LEVEL, default 8'd10: final level; clearing it wins the game.
REQ-002 SHALL have ports:
  clk  in  1  system clock, all state on rising edge
  reset  in  1  asynchronous, active-high reset
  start  in  1  level-sensitive request to begin or restart a game
  sec_tick  in  1  one-cycle pulse, once per second
  level_done  in  1  one-cycle pulse, player defused current level
  load_three  in  4  BCD hundreds of allotted seconds for game_level (from time-assignment block)
  load_two  in  4  BCD tens of allotted seconds
  load_one  in  4  BCD units of allotted seconds
  game_level  out  8  current level, drives time-assignment block
  digit_three  out  4  BCD hundreds of remaining seconds
  digit_two  out  4  BCD tens of remaining seconds
  digit_one  out  4  BCD units of remaining seconds
  running  out  1  high while countdown active
  level_up  out  1  one-cycle pulse per cleared level
  exploded  out  1  high while in BOOM
  won  out  1  high while in WIN

Function
REQ-003 SHALL implement FSM states IDLE, WAIT, LOAD, RUN, PASS, BOOM, WIN; all outputs registered.
REQ-004 IDLE: start=1 -> WAIT with game_level=0; otherwise hold.
REQ-005 WAIT: exactly one cycle, unconditionally -> LOAD; absorbs the one-cycle latency of the time-assignment block after a game_level change.
REQ-006 LOAD: exactly one cycle; capture load_three/two/one into digit_three/two/one; -> RUN.
REQ-007 RUN: running=1; on sec_tick decrement the 3-digit BCD count by one.
REQ-008 BCD decrement: digit_one 0 -> 9 with borrow to digit_two; digit_two 0 -> 9 with borrow to digit_three; never produces non-BCD values.
REQ-009 RUN: when a decrement yields 000 (count was 001 and sec_tick=1), next state BOOM on the same edge.
REQ-010 RUN: if count is 000 on entry (loaded 000), -> BOOM on the next edge regardless of inputs.
REQ-011 RUN: level_done=1 -> PASS; count frozen at its current value (no decrement that cycle).
REQ-012 Simultaneous level_done and sec_tick in RUN, including count 001: level_done wins -> PASS, count unchanged.
REQ-013 PASS: exactly one cycle, level_up=1; if game_level==LAST_LEVEL -> WIN with game_level held; else game_level+1 -> WAIT.
REQ-014 BOOM: exploded=1, digits held at 000; start=1 -> WAIT with game_level=0.
REQ-015 WIN: won=1, digits hold last value; start=1 -> WAIT with game_level=0.
REQ-016 start is ignored in WAIT, LOAD, RUN, PASS; level_done ignored outside RUN; sec_tick ignored outside RUN.
REQ-017 running, exploded, won SHALL be mutually exclusive; level_up only in PASS.
REQ-018 game_level SHALL change only on PASS (increment) or restart (0); never exceeds LAST_LEVEL.

Reset
REQ-019 reset=1 SHALL immediately, independent of clk, force state IDLE, game_level=0, digits=000, running=level_up=exploded=won=0.
REQ-020 reset asserted mid-RUN SHALL abandon the countdown; after release the block waits in IDLE for start.
REQ-021 First rising edge after reset deassertion SHALL evaluate normally from IDLE.

Verification
REQ-022 Reset, start pulse, loads=2,0,0 -> WAIT, LOAD, RUN; digits 2,0,0; 1 tick -> 1,9,9; 100 more ticks -> 0,9,9.
REQ-023 Loads 0,0,2 in RUN, two sec_ticks -> digits 0,0,1 then 0,0,0, state BOOM, exploded=1; later start -> game_level=0, WAIT.
REQ-024 Count 0,0,1 with level_done and sec_tick same cycle -> PASS, level_up one cycle, digits 0,0,1, game_level+1, then WAIT.
REQ-025 game_level=10 (LAST_LEVEL), level_done -> level_up pulse, WIN, won=1, game_level stays 10; start -> game_level 0.
REQ-026 reset asserted asynchronously mid-RUN at game_level=5 -> all outputs zero before next clk edge; start ignored while reset high.
REQ-027 level_done pulsed in IDLE, WAIT, BOOM; sec_tick in IDLE -> no state or output change.
